// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types for the round sequencers.
package aes_pkg;

    localparam int NR      = 10;   // rounds for AES-128
    localparam int BLOCK_W = 128;
    localparam int RKIDX_W = 4;

    // Byte order: byte 0 sits in the top byte, column-major as in FIPS-197.
    localparam int BYTE_W  = 8;
    localparam int NBYTES  = BLOCK_W / BYTE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    // Extract byte i (0 = most significant) of a block.
    function automatic logic [BYTE_W-1:0] blk_byte(input logic [BLOCK_W-1:0] b, input int i);
        return b[BLOCK_W-1-BYTE_W*i -: BYTE_W];
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: accepts a block, applies the
// initial AddRoundKey, steps an external round datapath through rounds
// 1..NR and holds the ciphertext until the consumer takes it.
module aes_round_sequencer
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    output logic [RKIDX_W-1:0] rk_idx,
    input  logic [BLOCK_W-1:0] rk,
    output logic [BLOCK_W-1:0] rnd_instate,
    output logic               rnd_final,
    input  logic [BLOCK_W-1:0] rnd_outstate,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block
);

    localparam logic [RKIDX_W-1:0] NR_IDX  = RKIDX_W'(NR);
    localparam logic [RKIDX_W-1:0] ONE_IDX = RKIDX_W'(1);

    fsm_e               fsm_q;
    logic [RKIDX_W-1:0] round_q;
    logic [BLOCK_W-1:0] state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               rnd_final_q;
    logic [RKIDX_W-1:0] rk_idx_q;

    logic [RKIDX_W-1:0] round_d;
    logic               round_ok;

    assign round_d  = round_q + ONE_IDX;
    // Counter values 0 and NR+1..15 cannot occur; if seen, fall back to IDLE.
    assign round_ok = (round_q != '0) && (round_q <= NR_IDX);

    // Control FSM; handshake and datapath-control outputs are registered
    // alongside the state so they change only on clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rnd_final_q <= 1'b0;
            rk_idx_q    <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        // rk is round key 0 here: initial AddRoundKey.
                        state_q     <= in_block ^ rk;
                        round_q     <= ONE_IDX;
                        fsm_q       <= ROUND;
                        in_ready_q  <= 1'b0;
                        rk_idx_q    <= ONE_IDX;
                        rnd_final_q <= (ONE_IDX == NR_IDX);
                    end
                end
                ROUND: begin
                    if (!round_ok) begin
                        fsm_q       <= IDLE;
                        round_q     <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        rnd_final_q <= 1'b0;
                        rk_idx_q    <= '0;
                    end else begin
                        state_q <= rnd_outstate;
                        if (round_q == NR_IDX) begin
                            fsm_q       <= DONE;
                            out_valid_q <= 1'b1;
                            rnd_final_q <= 1'b0;
                            rk_idx_q    <= '0;
                        end else begin
                            round_q     <= round_d;
                            rk_idx_q    <= round_d;
                            rnd_final_q <= (round_d == NR_IDX);
                        end
                    end
                end
                DONE: begin
                    // Ciphertext held until taken; no accept in this state.
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        round_q     <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    round_q     <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    rnd_final_q <= 1'b0;
                    rk_idx_q    <= '0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign rnd_final   = rnd_final_q;
    assign rk_idx      = rk_idx_q;
    assign rnd_instate = state_q;
    assign out_block   = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a behavioural AES round
// datapath and key schedule attached.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic [127:0] rnd_instate;
    logic         rnd_final;
    logic [127:0] rnd_outstate;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic [127:0] in_key = '0;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] S0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] S1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .rk_idx(rk_idx), .rk(rk),
        .rnd_instate(rnd_instate), .rnd_final(rnd_final), .rnd_outstate(rnd_outstate),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
    );

    // ---- behavioural AES pieces -------------------------------------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: inverse as a^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] p = a;
        logic [7:0] e = 8'd254;
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(blk_byte(s, i));
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r + 4*c] = b[r + 4*((c + r) % 4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    typedef logic [127:0] rk_arr_t [11];

    function automatic rk_arr_t expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        rk_arr_t     ks;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // Key schedule loads the offered key's schedule at accept.
    rk_arr_t rk_in;
    rk_arr_t rk_act;

    always_comb rk_in = expand(in_key);

    always @(posedge clk) if (in_valid && in_ready) rk_act <= rk_in;

    always_comb begin
        rk = '0;
        if (in_ready)          rk = rk_in[0];
        else if (rk_idx <= 10) rk = rk_act[rk_idx];
    end

    always_comb rnd_outstate = aes_round(rnd_instate, rk, rnd_final);

    // ---- checking ---------------------------------------------------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Runs one block from IDLE; returns at the first out_valid cycle (or bound).
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input bit noise,
                             output logic [127:0] ct, output int lat,
                             output logic [127:0] s1, output logic [127:0] s2);
        bit seq_ok = 1'b1;
        int fin_cnt = 0;
        int cyc = 0;
        s1 = '0; s2 = '0;
        @(negedge clk);
        chk("rdy_at_offer", in_ready, 1'b1);
        in_block = pt; in_key = key; in_valid = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            in_valid = noise && (cyc == 3 || cyc == 4);
            if (noise) in_block = ~pt;
            if (!out_valid) begin
                if (rk_idx != 4'(cyc) || in_ready) seq_ok = 1'b0;
                if (rnd_final) begin
                    fin_cnt++;
                    if (rk_idx != 4'd10) seq_ok = 1'b0;
                end
                if (cyc == 1) s1 = rnd_instate;
                if (cyc == 2) s2 = rnd_instate;
            end
        end while (!out_valid && cyc < 40);
        lat = cyc;
        ct  = out_block;
        chk("rkidx_seq", seq_ok, 1'b1);
        chk("final_once", fin_cnt, 1);
        if (noise) in_valid = 1'b1;
    endtask

    logic [127:0] ct, s1, s2, ct1, ct2;
    int lat;

    initial begin
        // reset
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rk_idx", rk_idx, 4'd0);
        chk("rst_final", rnd_final, 1'b0);
        chk("rst_out_block", out_block, '0);
        chk("rst_instate", rnd_instate, '0);
        rst = 1'b0;

        // App. B vector, consumer always ready
        out_ready = 1'b1;
        run_block(PT_B, KEY_B, 1'b0, ct, lat, s1, s2);
        chk("b_ct", ct, CT_B);
        chk("b_latency", lat, 11);
        chk("b_state_e0", s1, S0_B);
        chk("b_state_e1", s2, S1_B);
        @(negedge clk);
        chk("b_idle_rdy", in_ready, 1'b1);
        chk("b_idle_ov", out_valid, 1'b0);

        // Back-pressure on App. C vector
        begin
            bit stable = 1'b1;
            out_ready = 1'b0;
            run_block(PT_C, KEY_C, 1'b0, ct, lat, s1, s2);
            chk("c_ct", ct, CT_C);
            chk("c_latency", lat, 11);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!out_valid || in_ready || out_block !== CT_C) stable = 1'b0;
                in_valid = (i >= 5 && i < 15);
                in_block = PT_B;
            end
            chk("bp_stable", stable, 1'b1);
            @(negedge clk);
            chk("bp_still_ov", out_valid, 1'b1);
            chk("bp_still_ct", out_block, CT_C);
            out_ready = 1'b1;
            @(negedge clk);
            chk("bp_rel_rdy", in_ready, 1'b1);
            chk("bp_rel_ov", out_valid, 1'b0);
        end

        // in_valid pulsed during ROUND and DONE
        run_block(PT_B, KEY_B, 1'b1, ct, lat, s1, s2);
        chk("nz_ct", ct, CT_B);
        chk("nz_latency", lat, 11);
        @(negedge clk);
        in_valid = 1'b0;
        chk("nz_no_accept_done", in_ready, 1'b1);
        chk("nz_rk_idx", rk_idx, 4'd0);

        // Back-to-back with in_valid held high
        begin
            int acc1 = -1, acc2 = -1, nout = 0;
            bit sw = 1'b0, drop = 1'b0;
            @(negedge clk);
            in_block = PT_B; in_key = KEY_B; in_valid = 1'b1; out_ready = 1'b1;
            for (int c = 0; c < 40 && nout < 2; c++) begin
                if (sw)   begin in_block = PT_C; in_key = KEY_C; sw = 1'b0; end
                if (drop) begin in_valid = 1'b0; drop = 1'b0; end
                if (in_ready && in_valid) begin
                    if (acc1 < 0) begin acc1 = c; sw = 1'b1; end
                    else begin acc2 = c; drop = 1'b1; end
                end
                if (out_valid) begin
                    if (nout == 0) ct1 = out_block; else ct2 = out_block;
                    nout++;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("bb_nout", nout, 2);
            chk("bb_period", acc2 - acc1, 12);
            chk("bb_ct1", ct1, CT_B);
            chk("bb_ct2", ct2, CT_C);
        end

        // Reset in round 5
        begin
            bit spur = 1'b0;
            @(negedge clk);
            in_block = PT_B; in_key = KEY_B; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            for (int c = 0; c < 20 && rk_idx != 4'd5; c++) @(negedge clk);
            chk("mr_at_r5", rk_idx, 4'd5);
            rst = 1'b1;
            #1;
            chk("mr_in_ready", in_ready, 1'b1);
            chk("mr_out_valid", out_valid, 1'b0);
            chk("mr_state", rnd_instate, '0);
            chk("mr_rk_idx", rk_idx, 4'd0);
            chk("mr_final", rnd_final, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out_valid || !in_ready) spur = 1'b1;
            end
            chk("mr_no_spurious", spur, 1'b0);
            run_block(PT_B, KEY_B, 1'b0, ct, lat, s1, s2);
            chk("mr_ct", ct, CT_B);
            chk("mr_latency", lat, 11);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
